// File: rtl/spad_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// spad_pkg: shared types and constants for the scratch-pad arbiter
// Revision: 1.0
//------------------------------------------------------------------
package spad_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } spad_state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   localparam int SPAD_ADDR_W = 16;
   localparam int SPAD_DATA_W = 32;
   localparam int SPAD_CNT_W  = 8;

   function automatic logic [SPAD_CNT_W-1:0] sat_inc(input logic [SPAD_CNT_W-1:0] v,
                                                      input logic [SPAD_CNT_W-1:0] lim);
      return (v >= lim) ? lim : v + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spad_rr_pick.sv
`default_nettype none
//------------------------------------------------------------------
// spad_rr_pick: combinational 2-way grant picker with burst limit
// Revision: 1.0
//------------------------------------------------------------------
module spad_rr_pick
   import spad_pkg::*;
#(
   parameter int MAX_BURST = 8
) (
   input  spad_state_t           state,
   input  logic                  rr_ptr,
   input  logic [SPAD_CNT_W-1:0] burst_cnt,
   input  logic                  a_req,
   input  logic                  b_req,
   output logic [1:0]            gnt,
   output logic                  next_owner
);

   localparam logic [SPAD_CNT_W-1:0] c_max_cnt = SPAD_CNT_W'(MAX_BURST);

   logic w_at_max;
   assign w_at_max = (burst_cnt == c_max_cnt);

   always_comb begin
      gnt = 2'b00;
      case (state)
         IDLE: begin
            if (a_req && (!b_req || rr_ptr == PORT_A)) gnt = 2'b01;
            else if (b_req)                            gnt = 2'b10;
         end
         OWN_A: begin
            if (a_req && !(b_req && w_at_max)) gnt = 2'b01;
            else if (b_req)                    gnt = 2'b10;
         end
         OWN_B: begin
            if (b_req && !(a_req && w_at_max)) gnt = 2'b10;
            else if (a_req)                    gnt = 2'b01;
         end
         default: gnt = 2'b00;
      endcase
   end

   assign next_owner = gnt[1] ? PORT_B : PORT_A;

endmodule
`default_nettype wire

// File: rtl/spad_arbiter.sv
`default_nettype none
//------------------------------------------------------------------
// spad_arbiter: round-robin two-port arbiter for the scratch-pad SRAM
// Revision: 1.0
//------------------------------------------------------------------
module spad_arbiter
   import spad_pkg::*;
#(
   parameter int ADDR_W    = SPAD_ADDR_W,
   parameter int DATA_W    = SPAD_DATA_W,
   parameter int MAX_BURST = 8
) (
   input  logic              PORT1HCLK,
   input  logic              HRESETn,
   input  logic              a_req,
   input  logic [3:0]        a_wen,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   input  logic              b_req,
   input  logic [3:0]        b_wen,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              spad_en,
   output logic [3:0]        spad_wen,
   output logic [ADDR_W-1:0] spad_addr,
   output logic [DATA_W-1:0] spad_wdata,
   input  logic [DATA_W-1:0] spad_rdata
);

   localparam logic [SPAD_CNT_W-1:0] c_max_cnt = SPAD_CNT_W'(MAX_BURST);

   spad_state_t           r_state;
   logic [SPAD_CNT_W-1:0] r_burst_cnt;
   logic                  r_rr_ptr;
   logic                  r_a_rvalid;
   logic                  r_b_rvalid;
   logic [1:0]            w_pick;
   logic [1:0]            w_gnt;
   logic                  w_next_owner;
   logic                  w_same_owner;

   spad_rr_pick #(
      .MAX_BURST (MAX_BURST)
   ) u_pick (
      .state      (r_state),
      .rr_ptr     (r_rr_ptr),
      .burst_cnt  (r_burst_cnt),
      .a_req      (a_req),
      .b_req      (b_req),
      .gnt        (w_pick),
      .next_owner (w_next_owner)
   );

   // Grants are held off combinationally for the whole time reset is low.
   assign w_gnt = w_pick & {2{HRESETn}};
   assign a_gnt = w_gnt[0];
   assign b_gnt = w_gnt[1];

   assign w_same_owner = (w_next_owner == PORT_A && r_state == OWN_A) ||
                         (w_next_owner == PORT_B && r_state == OWN_B);

   always_ff @(posedge PORT1HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state     <= IDLE;
         r_burst_cnt <= '0;
         r_rr_ptr    <= PORT_A;
         r_a_rvalid  <= 1'b0;
         r_b_rvalid  <= 1'b0;
      end else begin
         r_a_rvalid <= w_gnt[0] && (a_wen == 4'h0);
         r_b_rvalid <= w_gnt[1] && (b_wen == 4'h0);
         if (|w_gnt) begin
            r_state <= (w_next_owner == PORT_A) ? OWN_A : OWN_B;
            if (w_same_owner) begin
               r_burst_cnt <= sat_inc(r_burst_cnt, c_max_cnt);
            end else begin
               r_burst_cnt <= SPAD_CNT_W'(1);
               r_rr_ptr    <= ~w_next_owner;
            end
         end else begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
         end
      end
   end

   assign a_rvalid = r_a_rvalid;
   assign b_rvalid = r_b_rvalid;
   assign rdata    = spad_rdata;
   assign spad_en  = |w_gnt;

   always_comb begin
      spad_wen   = 4'h0;
      spad_addr  = '0;
      spad_wdata = '0;
      if (w_gnt[0]) begin
         spad_wen   = a_wen;
         spad_addr  = a_addr;
         spad_wdata = a_wdata;
      end else if (w_gnt[1]) begin
         spad_wen   = b_wen;
         spad_addr  = b_addr;
         spad_wdata = b_wdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spad_arbiter.sv
`default_nettype none
//------------------------------------------------------------------
// tb_spad_arbiter: directed self-checking bench for spad_arbiter
// Revision: 1.0
//------------------------------------------------------------------
module tb_spad_arbiter;

   logic        PORT1HCLK = 1'b0;
   logic        HRESETn   = 1'b0;

   logic        a_req, b_req;
   logic [3:0]  a_wen, b_wen;
   logic [15:0] a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [31:0] rdata;
   logic        spad_en;
   logic [3:0]  spad_wen;
   logic [15:0] spad_addr;
   logic [31:0] spad_wdata;
   logic [31:0] spad_rdata = 32'h0;

   logic        m1_a_req = 1'b0, m1_b_req = 1'b0;
   logic [3:0]  m1_a_wen = 4'h0, m1_b_wen = 4'h0;
   logic [15:0] m1_a_addr = 16'h0, m1_b_addr = 16'h0;
   logic [31:0] m1_a_wdata = 32'h0, m1_b_wdata = 32'h0;
   logic        m1_a_gnt, m1_b_gnt, m1_a_rvalid, m1_b_rvalid;
   logic [31:0] m1_rdata;
   logic        m1_spad_en;
   logic [3:0]  m1_spad_wen;
   logic [15:0] m1_spad_addr;
   logic [31:0] m1_spad_wdata;
   logic [31:0] m1_spad_rdata = 32'h0;

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] mem [0:255];

   always #5 PORT1HCLK = ~PORT1HCLK;

   spad_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_BURST(8)) u_dut (
      .PORT1HCLK (PORT1HCLK), .HRESETn (HRESETn),
      .a_req (a_req), .a_wen (a_wen), .a_addr (a_addr), .a_wdata (a_wdata),
      .a_gnt (a_gnt), .a_rvalid (a_rvalid),
      .b_req (b_req), .b_wen (b_wen), .b_addr (b_addr), .b_wdata (b_wdata),
      .b_gnt (b_gnt), .b_rvalid (b_rvalid),
      .rdata (rdata), .spad_en (spad_en), .spad_wen (spad_wen),
      .spad_addr (spad_addr), .spad_wdata (spad_wdata), .spad_rdata (spad_rdata)
   );

   spad_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_BURST(1)) u_dut_m1 (
      .PORT1HCLK (PORT1HCLK), .HRESETn (HRESETn),
      .a_req (m1_a_req), .a_wen (m1_a_wen), .a_addr (m1_a_addr), .a_wdata (m1_a_wdata),
      .a_gnt (m1_a_gnt), .a_rvalid (m1_a_rvalid),
      .b_req (m1_b_req), .b_wen (m1_b_wen), .b_addr (m1_b_addr), .b_wdata (m1_b_wdata),
      .b_gnt (m1_b_gnt), .b_rvalid (m1_b_rvalid),
      .rdata (m1_rdata), .spad_en (m1_spad_en), .spad_wen (m1_spad_wen),
      .spad_addr (m1_spad_addr), .spad_wdata (m1_spad_wdata), .spad_rdata (m1_spad_rdata)
   );

   // Single-port SRAM model, 1-cycle read latency, byte writes
   always @(posedge PORT1HCLK) begin
      if (spad_en) begin
         if (spad_wen == 4'h0) spad_rdata <= mem[spad_addr[7:0]];
         else begin
            for (int i = 0; i < 4; i++)
               if (spad_wen[i]) mem[spad_addr[7:0]][8*i +: 8] <= spad_wdata[8*i +: 8];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_a(input logic req, input logic [3:0] wen, input logic [15:0] addr,
                        input logic [31:0] wdata);
      a_req = req; a_wen = wen; a_addr = addr; a_wdata = wdata;
   endtask

   task automatic set_b(input logic req, input logic [3:0] wen, input logic [15:0] addr,
                        input logic [31:0] wdata);
      b_req = req; b_wen = wen; b_addr = addr; b_wdata = wdata;
   endtask

   task automatic next_cycle();
      @(negedge PORT1HCLK);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h10] = 32'h1010_1010;
      mem[8'h20] = 32'h2020_2020;
      for (int i = 0; i <= 20; i++) mem[8'h40 + i] = 32'hB000_0000 + i;

      // Reset with both ports requesting reads
      set_a(1'b1, 4'h0, 16'h0010, 32'h0);
      set_b(1'b1, 4'h0, 16'h0020, 32'h0);
      next_cycle(); next_cycle(); #1;
      check("rst_a_gnt", a_gnt, 1'b0);
      check("rst_b_gnt", b_gnt, 1'b0);
      check("rst_spad_en", spad_en, 1'b0);
      check("rst_a_rvalid", a_rvalid, 1'b0);
      check("rst_b_rvalid", b_rvalid, 1'b0);

      // T1: A owns 8 cycles, then forced switch to B
      next_cycle(); HRESETn = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) next_cycle();
         #1;
         check($sformatf("t1_a_gnt_c%0d", k), a_gnt, (k < 8));
         check($sformatf("t1_b_gnt_c%0d", k), b_gnt, (k == 8));
         if (k == 0) check("t1_addr_c0", spad_addr, 16'h0010);
         if (k == 8) check("t1_addr_c8", spad_addr, 16'h0020);
         if (k == 1) begin
            check("t1_a_rvalid_c1", a_rvalid, 1'b1);
            check("t1_rdata_c1", rdata, 32'h1010_1010);
         end
      end
      next_cycle(); set_a(1'b0, 4'h0, 16'h0, 32'h0); set_b(1'b0, 4'h0, 16'h0, 32'h0); #1;
      check("t1_b_rvalid_c9", b_rvalid, 1'b1);
      check("t1_rdata_c9", rdata, 32'h2020_2020);
      check("t1_a_rvalid_c9", a_rvalid, 1'b0);
      next_cycle(); #1;
      check("t1_b_rvalid_c10", b_rvalid, 1'b0);

      // T2: A write then B read-back
      next_cycle(); set_a(1'b1, 4'hF, 16'h0004, 32'hDEAD_BEEF); #1;
      check("t2_a_gnt", a_gnt, 1'b1);
      check("t2_spad_wen", spad_wen, 4'hF);
      check("t2_spad_wdata", spad_wdata, 32'hDEAD_BEEF);
      next_cycle(); set_a(1'b0, 4'h0, 16'h0, 32'h0); set_b(1'b1, 4'h0, 16'h0004, 32'h0); #1;
      check("t2_b_gnt", b_gnt, 1'b1);
      check("t2_a_rvalid_n1", a_rvalid, 1'b0);
      next_cycle(); set_b(1'b0, 4'h0, 16'h0, 32'h0); #1;
      check("t2_b_rvalid", b_rvalid, 1'b1);
      check("t2_rdata", rdata, 32'hDEAD_BEEF);
      check("t2_a_rvalid_n2", a_rvalid, 1'b0);

      // T3: B streams 20 reads alone, then A is let in at the saturated limit
      for (int i = 0; i < 20; i++) begin
         next_cycle(); set_b(1'b1, 4'h0, 16'h0040 + 16'(i), 32'h0); #1;
         check($sformatf("t3_b_gnt_%0d", i), b_gnt, 1'b1);
         check($sformatf("t3_a_gnt_%0d", i), a_gnt, 1'b0);
         if (i > 0) begin
            check($sformatf("t3_b_rvalid_%0d", i), b_rvalid, 1'b1);
            check($sformatf("t3_rdata_%0d", i), rdata, 32'hB000_0000 + 32'(i - 1));
         end
      end
      next_cycle(); set_a(1'b1, 4'h0, 16'h0010, 32'h0); set_b(1'b1, 4'h0, 16'h0054, 32'h0); #1;
      check("t3_sat_a_gnt", a_gnt, 1'b1);
      check("t3_sat_b_gnt", b_gnt, 1'b0);
      check("t3_b_rvalid_20", b_rvalid, 1'b1);
      check("t3_rdata_20", rdata, 32'hB000_0013);
      next_cycle(); set_a(1'b0, 4'h0, 16'h0, 32'h0); #1;
      check("t3_b_regain", b_gnt, 1'b1);
      check("t3_a_rvalid", a_rvalid, 1'b1);
      check("t3_a_rdata", rdata, 32'h1010_1010);
      next_cycle(); set_b(1'b0, 4'h0, 16'h0, 32'h0); #1;
      check("t3_b_rvalid_last", b_rvalid, 1'b1);
      check("t3_rdata_last", rdata, 32'hB000_0014);

      // T4: owner A drops at cycle 3, B takes over with no bubble
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         set_a(k < 3, 4'h0, 16'h0060, 32'h0);
         set_b(1'b1, 4'h0, 16'h0061, 32'h0);
         #1;
         check($sformatf("t4_a_gnt_c%0d", k), a_gnt, (k < 3));
         check($sformatf("t4_b_gnt_c%0d", k), b_gnt, (k == 3));
         check($sformatf("t4_spad_en_c%0d", k), spad_en, 1'b1);
      end
      next_cycle(); set_a(1'b0, 4'h0, 16'h0, 32'h0); set_b(1'b0, 4'h0, 16'h0, 32'h0); #1;
      check("t4_idle_en", spad_en, 1'b0);
      next_cycle(); set_a(1'b1, 4'h0, 16'h0060, 32'h0); set_b(1'b1, 4'h0, 16'h0061, 32'h0); #1;
      check("t4_rr_a_gnt", a_gnt, 1'b1);
      check("t4_rr_b_gnt", b_gnt, 1'b0);
      next_cycle(); set_a(1'b0, 4'h0, 16'h0, 32'h0); set_b(1'b0, 4'h0, 16'h0, 32'h0);

      // T5: reset right after an A read grant
      next_cycle(); set_a(1'b1, 4'h0, 16'h0010, 32'h0); #1;
      check("t5_a_gnt", a_gnt, 1'b1);
      next_cycle(); HRESETn = 1'b0; set_b(1'b1, 4'h0, 16'h0020, 32'h0); #1;
      check("t5_rst_a_rvalid", a_rvalid, 1'b0);
      check("t5_rst_a_gnt", a_gnt, 1'b0);
      check("t5_rst_b_gnt", b_gnt, 1'b0);
      check("t5_rst_spad_en", spad_en, 1'b0);
      next_cycle(); #1;
      check("t5_rst2_a_gnt", a_gnt, 1'b0);
      check("t5_rst2_b_gnt", b_gnt, 1'b0);
      next_cycle(); HRESETn = 1'b1; set_a(1'b0, 4'h0, 16'h0, 32'h0); #1;
      check("t5_rel_b_gnt", b_gnt, 1'b1);
      check("t5_rel_a_rvalid", a_rvalid, 1'b0);
      next_cycle(); set_b(1'b0, 4'h0, 16'h0, 32'h0); #1;
      check("t5_b_rvalid", b_rvalid, 1'b1);
      check("t5_rdata", rdata, 32'h2020_2020);

      // T6: MAX_BURST = 1 build alternates every cycle
      for (int k = 0; k < 6; k++) begin
         next_cycle(); m1_a_req = 1'b1; m1_b_req = 1'b1; #1;
         check($sformatf("t6_a_gnt_c%0d", k), m1_a_gnt, (k % 2 == 0));
         check($sformatf("t6_b_gnt_c%0d", k), m1_b_gnt, (k % 2 == 1));
      end
      next_cycle(); m1_a_req = 1'b0; m1_b_req = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
